// File: rtl/demux_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// demux_dispatch_ctrl
//
// Credit-based dispatch controller sitting in front of a 1:4 demultiplexer.
// An upstream word is accepted when the credit counter of its target channel
// is non-zero; the accepted word, its channel select and a one-hot valid are
// registered towards the demux one cycle later. Each channel returns credits
// through single-cycle pulses on credit_return. Returning a credit to a channel
// that is already full is dropped and flagged on the sticky err_ovf output.
//
// Optional feature (macro DISPATCH_ROUND_ROBIN_EN):
//   defined   : the target channel comes from an internal 2-bit round-robin
//               pointer that advances on every accept; in_dest is ignored and
//               the block stalls on an empty channel rather than skipping it.
//   undefined : the target channel is in_dest.
//
// Parameters
//   N        data width in bits
//   CREDITS  per-channel credit depth, 1..15
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_data        upstream data word
//   in_dest        requested destination channel 0..3
//   in_valid       upstream word valid
//   in_ready       block can accept a word this cycle (combinational)
//   out_a          registered data to the demux data input
//   out_s          registered select to the demux select input
//   out_valid      registered one-hot qualifier for demux outputs z0..z3
//   credit_return  per-channel one-cycle credit return pulses
//   xfer_cnt       wrapping count of accepted words
//   err_ovf        sticky credit-overflow flag
// -----------------------------------------------------------------------------
module demux_dispatch_ctrl #(
    parameter int N       = 8,
    parameter int CREDITS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_dest,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_a,
    output logic [1:0]   out_s,
    output logic [3:0]   out_valid,
    input  logic [3:0]   credit_return,
    output logic [15:0]  xfer_cnt,
    output logic         err_ovf
);

    localparam logic [3:0] CREDIT_MAX = 4'(CREDITS);

    logic [3:0][3:0] credit_q;
    logic [3:0][3:0] credit_d;
    logic [N-1:0]    out_a_q;
    logic [N-1:0]    out_a_d;
    logic [1:0]      out_s_q;
    logic [1:0]      out_s_d;
    logic [3:0]      out_valid_q;
    logic [3:0]      out_valid_d;
    logic [15:0]     xfer_cnt_q;
    logic [15:0]     xfer_cnt_d;
    logic            err_ovf_q;
    logic            err_ovf_d;

    logic [1:0]      sel_s;
    logic            in_ready_s;
    logic            accept_s;
    logic [3:0]      take_s;
    logic            ovf_hit_s;

`ifdef DISPATCH_ROUND_ROBIN_EN
    logic [1:0]      ptr_q;
    logic [1:0]      ptr_d;

    assign sel_s = ptr_q;

    // Round-robin pointer next state: step once per accept, natural 2-bit wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_s) begin
            ptr_d = ptr_q + 2'd1;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign sel_s = in_dest;
`endif

    assign in_ready_s = (credit_q[sel_s] != 4'd0);
    assign in_ready   = in_ready_s;
    assign accept_s   = in_valid & in_ready_s;
    // One-hot of the channel consuming a credit this cycle (zero when idle).
    assign take_s     = accept_s ? (4'b0001 << sel_s) : 4'b0000;

    // Per-channel credit update. A return and a take on the same channel cancel,
    // so a full channel that is also being consumed does not count as overflow.
    always_comb begin
        credit_d  = credit_q;
        ovf_hit_s = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (credit_return[k] && take_s[k]) begin
                credit_d[k] = credit_q[k];
            end else if (take_s[k]) begin
                credit_d[k] = credit_q[k] - 4'd1;
            end else if (credit_return[k]) begin
                if (credit_q[k] == CREDIT_MAX) begin
                    credit_d[k] = credit_q[k];
                    ovf_hit_s   = 1'b1;
                end else begin
                    credit_d[k] = credit_q[k] + 4'd1;
                end
            end else begin
                credit_d[k] = credit_q[k];
            end
        end
    end

    // Output path next state: capture on accept, otherwise hold data/select
    // and drop the valid qualifier.
    always_comb begin
        out_a_d     = out_a_q;
        out_s_d     = out_s_q;
        out_valid_d = 4'b0000;
        xfer_cnt_d  = xfer_cnt_q;
        err_ovf_d   = err_ovf_q | ovf_hit_s;
        if (accept_s) begin
            out_a_d     = in_data;
            out_s_d     = sel_s;
            out_valid_d = take_s;
            xfer_cnt_d  = xfer_cnt_q + 16'd1;
        end else begin
            out_a_d     = out_a_q;
            out_s_d     = out_s_q;
            out_valid_d = 4'b0000;
            xfer_cnt_d  = xfer_cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q    <= {4{CREDIT_MAX}};
            out_a_q     <= {N{1'b0}};
            out_s_q     <= 2'd0;
            out_valid_q <= 4'b0000;
            xfer_cnt_q  <= 16'd0;
            err_ovf_q   <= 1'b0;
        end else begin
            credit_q    <= credit_d;
            out_a_q     <= out_a_d;
            out_s_q     <= out_s_d;
            out_valid_q <= out_valid_d;
            xfer_cnt_q  <= xfer_cnt_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign out_a     = out_a_q;
    assign out_s     = out_s_q;
    assign out_valid = out_valid_q;
    assign xfer_cnt  = xfer_cnt_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_demux_dispatch_ctrl
//
// Self-checking bench for demux_dispatch_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model that tracks
// credits as plain integers and predicts the registered outputs.
// -----------------------------------------------------------------------------
module tb_demux_dispatch_ctrl;

    localparam int N       = 8;
    localparam int CREDITS = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] in_data;
    logic [1:0]   in_dest;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_a;
    logic [1:0]   out_s;
    logic [3:0]   out_valid;
    logic [3:0]   credit_return;
    logic [15:0]  xfer_cnt;
    logic         err_ovf;

    demux_dispatch_ctrl #(.N(N), .CREDITS(CREDITS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_dest       (in_dest),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_a         (out_a),
        .out_s         (out_s),
        .out_valid     (out_valid),
        .credit_return (credit_return),
        .xfer_cnt      (xfer_cnt),
        .err_ovf       (err_ovf)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int err_cnt  = 0;

    // Reference model state.
    int           m_cred [4];
    int           m_ptr;
    logic [N-1:0] m_a;
    int           m_s;
    logic [3:0]   m_v;
    int           m_cnt;
    bit           m_ovf;
    bit           last_acc;

`ifdef DISPATCH_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Single comparison point for every check in the bench.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_cred[k] = CREDITS;
        m_ptr = 0;
        m_a   = '0;
        m_s   = 0;
        m_v   = 4'b0000;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic check_outputs(input string phase);
        check_val({phase, "_out_a"},     32'(out_a),     32'(m_a));
        check_val({phase, "_out_s"},     32'(out_s),     32'(m_s));
        check_val({phase, "_out_valid"}, 32'(out_valid), 32'(m_v));
        check_val({phase, "_xfer_cnt"},  32'(xfer_cnt),  32'(m_cnt));
        check_val({phase, "_err_ovf"},   32'(err_ovf),   32'(m_ovf));
    endtask

    // One clock of stimulus: drive after the falling edge, check in_ready,
    // advance the model across the rising edge, check the registered outputs.
    task automatic step(input logic v, input logic [1:0] d, input logic [N-1:0] dat,
                        input logic [3:0] ret);
        int  sel;
        bit  rdy;
        bit  acc;
        int  used;
        in_valid      = v;
        in_dest       = d;
        in_data       = dat;
        credit_return = ret;
        #1;
        sel = RR ? m_ptr : int'(d);
        rdy = (m_cred[sel] > 0);
        check_val("in_ready", 32'(in_ready), 32'(rdy));
        acc = v && rdy;
        for (int k = 0; k < 4; k++) begin
            used = (acc && sel == k) ? 1 : 0;
            if (ret[k] && used == 0 && m_cred[k] == CREDITS)
                m_ovf = 1'b1;
            else
                m_cred[k] = m_cred[k] + (ret[k] ? 1 : 0) - used;
        end
        if (acc) begin
            m_a   = dat;
            m_s   = sel;
            m_v   = 4'b0001 << sel;
            m_cnt = (m_cnt + 1) % 65536;
            m_ptr = (m_ptr + 1) % 4;
        end else begin
            m_v = 4'b0000;
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        check_outputs("step");
        @(negedge clk);
    endtask

    // Reset with a word on the input: nothing may be accepted or replayed.
    task automatic pulse_reset();
        in_valid      = 1'b1;
        in_dest       = 2'd1;
        in_data       = N'($urandom);
        credit_return = 4'b0000;
        rst_n         = 1'b0;
        model_reset();
        #1;
        check_outputs("rst_async");
        repeat (2) @(negedge clk);
        check_outputs("rst_hold");
        rst_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    logic [1:0]   r_dest;
    logic [N-1:0] r_data;
    logic         r_valid;
    int           rr_exp [5];

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_dest       = 2'd0;
        in_data       = '0;
        credit_return = 4'b0000;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;
        #1;
        check_val("reset_in_ready", 32'(in_ready), 32'd1);
        check_val("reset_out_valid", 32'(out_valid), 32'd0);
        check_val("reset_xfer_cnt", 32'(xfer_cnt), 32'd0);
        check_val("reset_err_ovf", 32'(err_ovf), 32'd0);
        @(negedge clk);

`ifndef DISPATCH_ROUND_ROBIN_EN
        // Single word to channel 2.
        step(1'b1, 2'd2, 8'hA5, 4'b0000);
        check_val("a5_out_a", 32'(out_a), 32'h0000_00A5);
        check_val("a5_out_s", 32'(out_s), 32'd2);
        check_val("a5_out_valid", 32'(out_valid), 32'h0000_0004);
        check_val("a5_xfer_cnt", 32'(xfer_cnt), 32'd1);

        // Drain channel 1, then a single return reopens it.
        for (int i = 0; i < CREDITS; i++) step(1'b1, 2'd1, N'($urandom), 4'b0000);
        in_dest = 2'd1;
        #1;
        check_val("d1_empty", 32'(in_ready), 32'd0);
        step(1'b0, 2'd1, '0, 4'b0010);
        #1;
        check_val("d1_reopen", 32'(in_ready), 32'd1);

        // Channel 0 down to one credit, then accept + return in the same cycle.
        for (int i = 0; i < CREDITS - 1; i++) step(1'b1, 2'd0, N'($urandom), 4'b0000);
        step(1'b1, 2'd0, 8'h3C, 4'b0001);
        in_dest = 2'd0;
        #1;
        check_val("d0_same_cycle", 32'(in_ready), 32'd1);
        step(1'b1, 2'd0, 8'h5A, 4'b0000);
        in_dest = 2'd0;
        #1;
        check_val("d0_now_empty", 32'(in_ready), 32'd0);
`else
        // Round-robin order from reset.
        rr_exp = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'($urandom), N'($urandom), 4'b0000);
            check_val("rr_order", 32'(out_s), 32'(rr_exp[i]));
        end
        // Empty channel 2 while the pointer sits on it: must stall, not skip.
        for (int i = 0; i < 2; i++) step(1'b1, 2'd0, N'($urandom), 4'b0000);
        while (m_cred[2] > 0) begin
            for (int i = 0; i < 4; i++) step(1'b1, 2'd0, N'($urandom), 4'b1011);
        end
        while (m_ptr != 2) step(1'b1, 2'd0, N'($urandom), 4'b1011);
        step(1'b1, 2'd3, N'($urandom), 4'b0000);
        check_val("rr_stall_valid", 32'(out_valid), 32'd0);
        check_val("rr_stall_ready", 32'(in_ready), 32'd0);
`endif

        // Overflow on channel 3 (full) and stickiness.
        pulse_reset();
        step(1'b0, 2'd0, '0, 4'b0000);
        step(1'b0, 2'd3, '0, 4'b1000);
        check_val("ovf_set", 32'(err_ovf), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 2'd0, '0, 4'b0000);
            check_val("ovf_sticky", 32'(err_ovf), 32'd1);
        end

        // Word in flight right before reset is not replayed afterwards.
        step(1'b1, 2'd2, 8'h77, 4'b0000);
        pulse_reset();
        step(1'b0, 2'd2, '0, 4'b0000);

        // Randomized traffic; upstream holds an unaccepted word.
        r_valid = 1'b0;
        r_dest  = 2'd0;
        r_data  = '0;
        for (int i = 0; i < 600; i++) begin
            if (!(r_valid && !last_acc)) begin
                r_valid = ($urandom_range(0, 3) != 0);
                r_dest  = 2'($urandom);
                r_data  = N'($urandom);
            end
            step(r_valid, r_dest, r_data, 4'($urandom) & 4'($urandom) & 4'($urandom));
            if (i == 300) pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
